// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter and its round-robin helper.
package mem_arb_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned MEM_LATENCY = 4;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned CNT_W       = 4;

  localparam logic [ADDR_W-1:0] BLOCK_OFFSET_MASK = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  // Byte address of word idx inside a block; wraps within ADDR_W bits.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + ADDR_W'({idx, 1'b0});
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer toggles on each advance pulse.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_ic_i,
  input  logic req_dc_i,
  input  logic advance_i,
  output logic gnt_ic_c_o,
  output logic gnt_dc_c_o
);

  // 1: D wins a tie, 0: I wins a tie
  logic ptr_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_d_q <= 1'b1;
    end else if (advance_i) begin
      ptr_d_q <= ~ptr_d_q;
    end
  end

  assign gnt_dc_c_o = req_dc_i && (!req_ic_i || ptr_d_q);
  assign gnt_ic_c_o = req_ic_i && (!req_dc_i || !ptr_d_q);

endmodule

// File: rtl/mem_arbiter_fsm.sv
// Shared memory-port sequencer: arbitrates I/D block fills and write-through stores,
// issues pipelined word reads and steers returning words to the owning cache.
module mem_arbiter_fsm
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  input  logic              dcache_wr,
  input  logic [ADDR_W-1:0] dcache_wr_addr,
  input  logic [DATA_W-1:0] dcache_wr_data,
  output logic              icache_fill_valid,
  output logic              dcache_fill_valid,
  output logic [DATA_W-1:0] fill_data,
  output logic [IDX_W-1:0]  fill_word_idx,
  output logic              icache_fill_done,
  output logic              dcache_fill_done,
  output logic              dcache_wr_ack,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid
);

  state_e            state_q;
  owner_e            owner_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic [IDX_W-1:0]  recv_cnt_q;
  logic              mem_enable_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              wr_ack_q;

  logic              gnt_i;
  logic              gnt_d;
  logic              word_in;
  logic              last_word;
  logic [ADDR_W-1:0] grant_base;

  assign word_in    = (state_q == FILL) && mem_data_valid;
  assign last_word  = word_in && (recv_cnt_q == IDX_W'(BLOCK_WORDS - 1));
  assign grant_base = (gnt_d ? dcache_miss_addr : icache_miss_addr) & BLOCK_OFFSET_MASK;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_ic_i   (icache_miss),
    .req_dc_i   (dcache_miss),
    .advance_i  (last_word),
    .gnt_ic_c_o (gnt_i),
    .gnt_dc_c_o (gnt_d)
  );

  // Sequencer; memory-side outputs default to idle every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      base_q       <= '0;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      mem_enable_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_ack_q     <= 1'b0;
    end else begin
      mem_enable_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_ack_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dcache_wr) begin
            state_q      <= WRITE;
            mem_enable_q <= 1'b1;
            mem_wr_q     <= 1'b1;
            mem_addr_q   <= dcache_wr_addr;
            mem_wdata_q  <= dcache_wr_data;
            wr_ack_q     <= 1'b1;
          end else if (gnt_i || gnt_d) begin
            state_q      <= FILL;
            owner_q      <= gnt_d ? OWN_D : OWN_I;
            base_q       <= grant_base;
            mem_enable_q <= 1'b1;
            mem_addr_q   <= grant_base;
            issue_cnt_q  <= CNT_W'(1);
            recv_cnt_q   <= '0;
          end
        end
        WRITE: begin
          state_q <= IDLE;
        end
        FILL: begin
          // issue_cnt_q counts words already placed on the port
          if (issue_cnt_q < CNT_W'(BLOCK_WORDS)) begin
            mem_enable_q <= 1'b1;
            mem_addr_q   <= word_addr(base_q, issue_cnt_q);
            issue_cnt_q  <= issue_cnt_q + CNT_W'(1);
          end
          if (word_in) begin
            recv_cnt_q <= recv_cnt_q + IDX_W'(1);
          end
          if (last_word) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Return path is combinational so each word reaches its cache in its arrival cycle.
  always_comb begin
    icache_fill_valid = 1'b0;
    dcache_fill_valid = 1'b0;
    icache_fill_done  = 1'b0;
    dcache_fill_done  = 1'b0;
    fill_data         = '0;
    fill_word_idx     = '0;
    if (word_in) begin
      fill_data     = mem_data_out;
      fill_word_idx = recv_cnt_q;
      if (owner_q == OWN_D) begin
        dcache_fill_valid = 1'b1;
        dcache_fill_done  = last_word;
      end else begin
        icache_fill_valid = 1'b1;
        icache_fill_done  = last_word;
      end
    end
  end

  assign mem_enable    = mem_enable_q;
  assign mem_wr        = mem_wr_q;
  assign mem_addr      = mem_addr_q;
  assign mem_data_in   = mem_wdata_q;
  assign dcache_wr_ack = wr_ack_q;

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Bench for mem_arbiter_fsm: pipelined memory responder, transaction-level
// reference model checked every cycle, and directed scenarios with literal pins.
module tb_mem_arbiter_fsm;
  import mem_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              icache_miss = 1'b0;
  logic [ADDR_W-1:0] icache_miss_addr = '0;
  logic              dcache_miss = 1'b0;
  logic [ADDR_W-1:0] dcache_miss_addr = '0;
  logic              dcache_wr = 1'b0;
  logic [ADDR_W-1:0] dcache_wr_addr = '0;
  logic [DATA_W-1:0] dcache_wr_data = '0;
  logic              icache_fill_valid, dcache_fill_valid;
  logic [DATA_W-1:0] fill_data;
  logic [IDX_W-1:0]  fill_word_idx;
  logic              icache_fill_done, dcache_fill_done, dcache_wr_ack;
  logic              mem_enable, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_data_valid;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .icache_miss       (icache_miss),
    .icache_miss_addr  (icache_miss_addr),
    .dcache_miss       (dcache_miss),
    .dcache_miss_addr  (dcache_miss_addr),
    .dcache_wr         (dcache_wr),
    .dcache_wr_addr    (dcache_wr_addr),
    .dcache_wr_data    (dcache_wr_data),
    .icache_fill_valid (icache_fill_valid),
    .dcache_fill_valid (dcache_fill_valid),
    .fill_data         (fill_data),
    .fill_word_idx     (fill_word_idx),
    .icache_fill_done  (icache_fill_done),
    .dcache_fill_done  (dcache_fill_done),
    .dcache_wr_ack     (dcache_wr_ack),
    .mem_enable        (mem_enable),
    .mem_wr            (mem_wr),
    .mem_addr          (mem_addr),
    .mem_data_in       (mem_data_in),
    .mem_data_out      (mem_data_out),
    .mem_data_valid    (mem_data_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Pipelined read memory, not reset: reads return MEM_LATENCY cycles after issue.
  logic [MEM_LATENCY-1:0] pv = '0;
  logic [ADDR_W-1:0]      pa [MEM_LATENCY];
  always @(posedge clk) begin
    pv    <= {pv[MEM_LATENCY-2:0], mem_enable && !mem_wr};
    pa[0] <= mem_addr;
    for (int i = MEM_LATENCY - 1; i > 0; i--) pa[i] <= pa[i-1];
  end
  assign mem_data_valid = pv[MEM_LATENCY-1];
  assign mem_data_out   = mem_data_valid ? mem_word(pa[MEM_LATENCY-1]) : 16'hDEAD;

  // Reference model: current job (0 none, 1 store, 2 fill) and cycles since its grant.
  int                m_job = 0;
  bit                m_own_d = 1'b0;
  bit                m_ptr_d = 1'b1;
  logic [ADDR_W-1:0] m_base = '0;
  logic [ADDR_W-1:0] m_wa = '0;
  logic [DATA_W-1:0] m_wd = '0;
  int                m_t = 0;
  int                m_recv = 0;

  initial begin : model
    bit gi, gd;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_job   = 0;
        m_ptr_d = 1'b1;
      end else begin
        case (m_job)
          0: begin
            gi = icache_miss && (!dcache_miss || !m_ptr_d);
            gd = dcache_miss && (!icache_miss || m_ptr_d);
            if (dcache_wr) begin
              m_job = 1;
              m_wa  = dcache_wr_addr;
              m_wd  = dcache_wr_data;
            end else if (gi || gd) begin
              m_job   = 2;
              m_own_d = gd;
              m_base  = (gd ? dcache_miss_addr : icache_miss_addr) & 16'hFFF0;
              m_t     = 1;
              m_recv  = 0;
            end
          end
          1: m_job = 0;
          default: begin
            m_t++;
            if (mem_data_valid) begin
              m_recv++;
              if (m_recv == BLOCK_WORDS) begin
                m_job   = 0;
                m_ptr_d = !m_ptr_d;
              end
            end
          end
        endcase
      end
    end
  end

  initial begin : compare
    bit                e_en, e_v;
    logic [ADDR_W-1:0] e_addr;
    forever begin
      @(negedge clk);
      e_en   = (m_job == 1) || (m_job == 2 && m_t <= BLOCK_WORDS);
      e_v    = (m_job == 2) && mem_data_valid;
      e_addr = (m_job == 1) ? m_wa : m_base + 16'((m_t - 1) * 2);
      chk("mem_enable", 16'(mem_enable), 16'(e_en));
      chk("mem_wr", 16'(mem_wr), 16'(m_job == 1));
      chk("dcache_wr_ack", 16'(dcache_wr_ack), 16'(m_job == 1));
      chk("icache_fill_valid", 16'(icache_fill_valid), 16'(e_v && !m_own_d));
      chk("dcache_fill_valid", 16'(dcache_fill_valid), 16'(e_v && m_own_d));
      chk("icache_fill_done", 16'(icache_fill_done), 16'(e_v && !m_own_d && m_recv == 7));
      chk("dcache_fill_done", 16'(dcache_fill_done), 16'(e_v && m_own_d && m_recv == 7));
      if (e_en) chk("mem_addr", mem_addr, e_addr);
      if (m_job == 1) chk("mem_data_in", mem_data_in, m_wd);
      if (e_v) begin
        chk("fill_word_idx", 16'(fill_word_idx), 16'(m_recv));
        chk("fill_data", fill_data, mem_word(m_base + 16'(m_recv * 2)));
      end
      if (m_job == 0) begin
        chk("idle_mem_addr", mem_addr, 16'h0000);
        chk("idle_mem_data_in", mem_data_in, 16'h0000);
        chk("idle_fill_data", fill_data, 16'h0000);
        chk("idle_fill_word_idx", 16'(fill_word_idx), 16'h0000);
      end
    end
  end

  // Advance n cycles; requesters drop their request on done/ack like real caches.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      if (icache_fill_done) icache_miss = 1'b0;
      if (dcache_fill_done) dcache_miss = 1'b0;
      if (dcache_wr_ack)    dcache_wr   = 1'b0;
    end
  endtask

  initial begin : stim
    tick(3);
    chk("rst_mem_enable", 16'(mem_enable), 16'h0000);
    rst_n = 1'b1;
    tick(2);

    // Lone I-miss at 0x0136
    icache_miss = 1'b1; icache_miss_addr = 16'h0136;
    tick(1); chk("t1_addr_c1", mem_addr, 16'h0130);
    tick(4); chk("t1_ivalid_c5", 16'(icache_fill_valid), 16'h0001);
    chk("t1_data_c5", fill_data, 16'h5B0C);
    tick(3); chk("t1_addr_c8", mem_addr, 16'h013E);
    tick(1); chk("t1_en_c9", 16'(mem_enable), 16'h0000);
    tick(3); chk("t1_idone_c12", 16'(icache_fill_done), 16'h0001);
    chk("t1_idx_c12", 16'(fill_word_idx), 16'h0007);
    tick(1); chk("t1_idle_c13", 16'(icache_fill_valid), 16'h0000);
    tick(1);

    // Both misses from reset: D first, then I wins against a re-raised D
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(2);
    icache_miss = 1'b1; icache_miss_addr = 16'h0400;
    dcache_miss = 1'b1; dcache_miss_addr = 16'h0800;
    tick(1);  chk("t2_d_first", mem_addr, 16'h0800);
    tick(11); chk("t2_ddone_c12", 16'(dcache_fill_done), 16'h0001);
    tick(1);  dcache_miss = 1'b1; dcache_miss_addr = 16'h0A10;
    tick(1);  chk("t2_i_second", mem_addr, 16'h0400);
    tick(13); chk("t2_d_third", mem_addr, 16'h0A10);
    tick(13);

    // Store together with a D-miss
    dcache_wr = 1'b1; dcache_wr_addr = 16'h2004; dcache_wr_data = 16'hBEEF;
    dcache_miss = 1'b1; dcache_miss_addr = 16'h3000;
    tick(1); chk("t3_wr_c1", 16'(mem_wr), 16'h0001);
    chk("t3_waddr_c1", mem_addr, 16'h2004);
    chk("t3_wdata_c1", mem_data_in, 16'hBEEF);
    chk("t3_ack_c1", 16'(dcache_wr_ack), 16'h0001);
    tick(1); chk("t3_en_c2", 16'(mem_enable), 16'h0000);
    tick(1); chk("t3_fill_c3", mem_addr, 16'h3000);
    tick(13);

    // Store arriving during a fill waits for the next IDLE
    dcache_miss = 1'b1; dcache_miss_addr = 16'h1234;
    tick(4); dcache_wr = 1'b1; dcache_wr_addr = 16'h5556; dcache_wr_data = 16'h1234;
    tick(9); chk("t4_held_c13", 16'(mem_enable), 16'h0000);
    tick(1); chk("t4_wr_c14", 16'(mem_wr), 16'h0001);
    chk("t4_waddr_c14", mem_addr, 16'h5556);
    chk("t4_wdata_c14", mem_data_in, 16'h1234);
    tick(2);

    // Top-of-memory block does not wrap
    dcache_miss = 1'b1; dcache_miss_addr = 16'hFFF8;
    tick(1);  chk("t5_addr_c1", mem_addr, 16'hFFF0);
    tick(7);  chk("t5_addr_c8", mem_addr, 16'hFFFE);
    tick(4);  chk("t5_data_c12", fill_data, 16'hA5C2);
    chk("t5_ddone_c12", 16'(dcache_fill_done), 16'h0001);
    tick(2);

    // Reset in cycle 6 of a fill, then a clean refill
    icache_miss = 1'b1; icache_miss_addr = 16'h0C40;
    tick(6); rst_n = 1'b0; icache_miss = 1'b0;
    tick(1); chk("t6_rst_en", 16'(mem_enable), 16'h0000);
    chk("t6_rst_addr", mem_addr, 16'h0000);
    rst_n = 1'b1;
    tick(1); chk("t6_stale_ivalid", 16'(icache_fill_valid), 16'h0000);
    tick(4);
    icache_miss = 1'b1; icache_miss_addr = 16'h0C40;
    tick(12); chk("t6_idone", 16'(icache_fill_done), 16'h0001);
    chk("t6_data", fill_data, 16'h5672);
    chk("t6_idx", 16'(fill_word_idx), 16'h0007);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
